// File: rtl/pwm_ctrl_sched.sv
// pwm_ctrl_sched: command scheduler for a two-channel PWM generator.
// Software commands land in one shadow slot and are applied on a PWM period
// boundary. Active values slew toward their targets by at most slew_step_i per
// period. A period-based watchdog falls back to failsafe active values when
// commands stop arriving.
module pwm_ctrl_sched #(
  parameter int CNT_WIDTH = 24,
  parameter int STEP_W    = 16,
  parameter int WD_W      = 8
) (
  input  logic                 axi_clk,
  input  logic                 axi_rst,
  input  logic                 enable_i,
  input  logic                 cmd_valid_i,
  output logic                 cmd_ready_o,
  input  logic [CNT_WIDTH-1:0] cmd_period_i,
  input  logic [CNT_WIDTH-1:0] cmd_active_0_i,
  input  logic [CNT_WIDTH-1:0] cmd_active_1_i,
  input  logic [STEP_W-1:0]    slew_step_i,
  input  logic [WD_W-1:0]      wdog_limit_i,
  input  logic [CNT_WIDTH-1:0] fs_active_0_i,
  input  logic [CNT_WIDTH-1:0] fs_active_1_i,
  output logic                 pwm_enable_o,
  output logic [CNT_WIDTH-1:0] pwm_period_o,
  output logic [CNT_WIDTH-1:0] pwm_active_0_o,
  output logic [CNT_WIDTH-1:0] pwm_active_1_o,
  output logic [1:0]           state_o,
  output logic                 fs_event_o
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_RUN  = 2'd1;
  localparam logic [1:0] ST_FS   = 2'd2;

  // Common width for comparing an active-value difference against the step.
  localparam int DW = (CNT_WIDTH > STEP_W) ? CNT_WIDTH : STEP_W;

  localparam logic [CNT_WIDTH-1:0] CNT_ZERO = {CNT_WIDTH{1'b0}};
  localparam logic [CNT_WIDTH-1:0] CNT_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WD_W-1:0]      WD_ZERO  = {WD_W{1'b0}};
  localparam logic [WD_W:0]        WD_ONE   = {{WD_W{1'b0}}, 1'b1};

  // Move cur toward tgt by at most step; a zero step jumps straight to tgt.
  // The step is only added/subtracted when it is strictly smaller than the
  // distance, so the result never overshoots or wraps.
  function automatic logic [CNT_WIDTH-1:0] slew_f(
    input logic [CNT_WIDTH-1:0] cur,
    input logic [CNT_WIDTH-1:0] tgt,
    input logic [STEP_W-1:0]    step
  );
    logic [DW-1:0]        diff_w;
    logic [DW-1:0]        step_w;
    logic [CNT_WIDTH-1:0] res;
    step_w = DW'(step);
    diff_w = {DW{1'b0}};
    res    = tgt;
    if (step == {STEP_W{1'b0}}) begin
      res = tgt;
    end else if (tgt > cur) begin
      diff_w = DW'(tgt - cur);
      if (diff_w > step_w) res = cur + CNT_WIDTH'(step);
      else                 res = tgt;
    end else begin
      diff_w = DW'(cur - tgt);
      if (diff_w > step_w) res = cur - CNT_WIDTH'(step);
      else                 res = tgt;
    end
    return res;
  endfunction

  logic [1:0]           state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [CNT_WIDTH-1:0] period_q, period_d;
  logic [CNT_WIDTH-1:0] act0_q, act0_d;
  logic [CNT_WIDTH-1:0] act1_q, act1_d;
  logic [CNT_WIDTH-1:0] tgt0_q, tgt0_d;
  logic [CNT_WIDTH-1:0] tgt1_q, tgt1_d;
  logic [CNT_WIDTH-1:0] slot_period_q, slot_period_d;
  logic [CNT_WIDTH-1:0] slot_act0_q, slot_act0_d;
  logic [CNT_WIDTH-1:0] slot_act1_q, slot_act1_d;
  logic                 pending_q, pending_d;
  logic [WD_W-1:0]      wd_cnt_q, wd_cnt_d;
  logic                 ready_q, ready_d;
  logic                 pwm_en_q, pwm_en_d;
  logic                 fs_event_q, fs_event_d;

  logic                 active_s;
  logic                 boundary_s;
  logic                 apply_s;
  logic                 expire_s;
  logic                 accept_s;
  logic [WD_W:0]        wd_inc_s;

  assign active_s   = enable_i && (state_q != ST_IDLE);
  // Period 0 or 1 degenerates to a boundary on every cycle.
  assign boundary_s = active_s &&
                      ((period_q <= CNT_ONE) || (cnt_q == (period_q - CNT_ONE)));
  assign apply_s    = boundary_s && pending_q;
  assign wd_inc_s   = {1'b0, wd_cnt_q} + WD_ONE;
  // A pending command at the same boundary suppresses the watchdog.
  assign expire_s   = boundary_s && !pending_q && (state_q == ST_RUN) &&
                      (wdog_limit_i != WD_ZERO) &&
                      (wd_inc_s >= {1'b0, wdog_limit_i});
  assign accept_s   = active_s && cmd_valid_i && ready_q;

  // State register.
  always_ff @(posedge axi_clk or posedge axi_rst) begin
    if (axi_rst) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  // Next-state logic; dropping enable_i wins from any state.
  always_comb begin
    state_d = state_q;
    if (!enable_i) begin
      state_d = ST_IDLE;
    end else begin
      case (state_q)
        ST_IDLE: state_d = ST_RUN;
        ST_RUN:  state_d = expire_s ? ST_FS : ST_RUN;
        ST_FS:   state_d = apply_s ? ST_RUN : ST_FS;
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Registered control outputs derived from the next state and slot status.
  always_comb begin
    pwm_en_d   = (state_d != ST_IDLE);
    ready_d    = (state_d != ST_IDLE) && !pending_d;
    fs_event_d = enable_i && expire_s;
  end

  // Datapath: period counter, shadow slot, slew, target update, watchdog.
  always_comb begin
    cnt_d         = cnt_q;
    period_d      = period_q;
    act0_d        = act0_q;
    act1_d        = act1_q;
    tgt0_d        = tgt0_q;
    tgt1_d        = tgt1_q;
    slot_period_d = slot_period_q;
    slot_act0_d   = slot_act0_q;
    slot_act1_d   = slot_act1_q;
    pending_d     = pending_q;
    wd_cnt_d      = wd_cnt_q;
    if (!active_s) begin
      cnt_d     = CNT_ZERO;
      wd_cnt_d  = WD_ZERO;
      pending_d = 1'b0;
    end else begin
      cnt_d = boundary_s ? CNT_ZERO : (cnt_q + CNT_ONE);
      // Slew uses the targets in force before this boundary's update.
      if (boundary_s) begin
        act0_d = slew_f(act0_q, tgt0_q, slew_step_i);
        act1_d = slew_f(act1_q, tgt1_q, slew_step_i);
      end else begin
        act0_d = act0_q;
        act1_d = act1_q;
      end
      if (apply_s) begin
        period_d  = slot_period_q;
        tgt0_d    = slot_act0_q;
        tgt1_d    = slot_act1_q;
        pending_d = 1'b0;
        wd_cnt_d  = WD_ZERO;
      end else if (expire_s) begin
        tgt0_d   = fs_active_0_i;
        tgt1_d   = fs_active_1_i;
        wd_cnt_d = WD_ZERO;
      end else if (boundary_s && (state_q == ST_RUN) && (wdog_limit_i != WD_ZERO)) begin
        wd_cnt_d = wd_inc_s[WD_W-1:0];
      end else begin
        wd_cnt_d = wd_cnt_q;
      end
      // Ready is low whenever the slot is full, so accept never collides with apply.
      if (accept_s) begin
        slot_period_d = cmd_period_i;
        slot_act0_d   = cmd_active_0_i;
        slot_act1_d   = cmd_active_1_i;
        pending_d     = 1'b1;
      end else begin
        slot_period_d = slot_period_q;
      end
    end
  end

  // Datapath and output registers.
  always_ff @(posedge axi_clk or posedge axi_rst) begin
    if (axi_rst) begin
      cnt_q         <= CNT_ZERO;
      period_q      <= CNT_ZERO;
      act0_q        <= CNT_ZERO;
      act1_q        <= CNT_ZERO;
      tgt0_q        <= CNT_ZERO;
      tgt1_q        <= CNT_ZERO;
      slot_period_q <= CNT_ZERO;
      slot_act0_q   <= CNT_ZERO;
      slot_act1_q   <= CNT_ZERO;
      pending_q     <= 1'b0;
      wd_cnt_q      <= WD_ZERO;
      ready_q       <= 1'b0;
      pwm_en_q      <= 1'b0;
      fs_event_q    <= 1'b0;
    end else begin
      cnt_q         <= cnt_d;
      period_q      <= period_d;
      act0_q        <= act0_d;
      act1_q        <= act1_d;
      tgt0_q        <= tgt0_d;
      tgt1_q        <= tgt1_d;
      slot_period_q <= slot_period_d;
      slot_act0_q   <= slot_act0_d;
      slot_act1_q   <= slot_act1_d;
      pending_q     <= pending_d;
      wd_cnt_q      <= wd_cnt_d;
      ready_q       <= ready_d;
      pwm_en_q      <= pwm_en_d;
      fs_event_q    <= fs_event_d;
    end
  end

  assign cmd_ready_o    = ready_q;
  assign pwm_enable_o   = pwm_en_q;
  assign pwm_period_o   = period_q;
  assign pwm_active_0_o = act0_q;
  assign pwm_active_1_o = act1_q;
  assign state_o        = state_q;
  assign fs_event_o     = fs_event_q;

endmodule

// File: tb/tb_pwm_ctrl_sched.sv
// Directed testbench for pwm_ctrl_sched. Scenarios run back to back on one
// continuous timeline; cycle offsets in comments are relative to the most
// recent boundary that applied a command (P0) within each scenario chain.
module tb_pwm_ctrl_sched;

  logic        axi_clk = 1'b0;
  logic        axi_rst;
  logic        enable_i;
  logic        cmd_valid_i;
  logic        cmd_ready_o;
  logic [23:0] cmd_period_i, cmd_active_0_i, cmd_active_1_i;
  logic [15:0] slew_step_i;
  logic [7:0]  wdog_limit_i;
  logic [23:0] fs_active_0_i, fs_active_1_i;
  logic        pwm_enable_o;
  logic [23:0] pwm_period_o, pwm_active_0_o, pwm_active_1_o;
  logic [1:0]  state_o;
  logic        fs_event_o;

  int tests  = 0;
  int failed = 0;

  pwm_ctrl_sched dut (
    .axi_clk(axi_clk), .axi_rst(axi_rst), .enable_i(enable_i),
    .cmd_valid_i(cmd_valid_i), .cmd_ready_o(cmd_ready_o),
    .cmd_period_i(cmd_period_i), .cmd_active_0_i(cmd_active_0_i),
    .cmd_active_1_i(cmd_active_1_i), .slew_step_i(slew_step_i),
    .wdog_limit_i(wdog_limit_i), .fs_active_0_i(fs_active_0_i),
    .fs_active_1_i(fs_active_1_i), .pwm_enable_o(pwm_enable_o),
    .pwm_period_o(pwm_period_o), .pwm_active_0_o(pwm_active_0_o),
    .pwm_active_1_o(pwm_active_1_o), .state_o(state_o), .fs_event_o(fs_event_o)
  );

  always #5 axi_clk = ~axi_clk;

  task automatic cyc(input int n);
    repeat (n) begin
      @(posedge axi_clk);
      #1;
    end
  endtask

  task automatic test_reset;
    tests++; if (state_o !== 2'd0) begin failed++; $display("FAIL rst_state got %0d exp 0", state_o); end
    tests++; if ({pwm_enable_o, cmd_ready_o, fs_event_o} !== 3'b000) begin failed++; $display("FAIL rst_ctrl got %b exp 000", {pwm_enable_o, cmd_ready_o, fs_event_o}); end
    tests++; if ({pwm_period_o, pwm_active_0_o, pwm_active_1_o} !== 72'd0) begin failed++; $display("FAIL rst_data got %0d/%0d/%0d exp 0/0/0", pwm_period_o, pwm_active_0_o, pwm_active_1_o); end
  endtask

  task automatic test_basic_apply;
    axi_rst = 1'b0; enable_i = 1'b1;
    cyc(1);
    tests++; if (state_o !== 2'd1) begin failed++; $display("FAIL run_state got %0d exp 1", state_o); end
    tests++; if (pwm_enable_o !== 1'b1) begin failed++; $display("FAIL run_pwm_en got %b exp 1", pwm_enable_o); end
    tests++; if (cmd_ready_o !== 1'b1) begin failed++; $display("FAIL run_ready got %b exp 1", cmd_ready_o); end
    cmd_valid_i = 1'b1; cmd_period_i = 24'd10; cmd_active_0_i = 24'd3; cmd_active_1_i = 24'd7;
    cyc(1); // accept edge
    cmd_valid_i = 1'b0;
    tests++; if (cmd_ready_o !== 1'b0) begin failed++; $display("FAIL pend_ready got %b exp 0", cmd_ready_o); end
    tests++; if (pwm_period_o !== 24'd0) begin failed++; $display("FAIL pend_period got %0d exp 0", pwm_period_o); end
    cyc(1); // next boundary (period 0) applies the command
    tests++; if (pwm_period_o !== 24'd10) begin failed++; $display("FAIL apply_period got %0d exp 10", pwm_period_o); end
    tests++; if (cmd_ready_o !== 1'b1) begin failed++; $display("FAIL apply_ready got %b exp 1", cmd_ready_o); end
    cyc(10); // first boundary of the 10-cycle period
    tests++; if (pwm_active_0_o !== 24'd3 || pwm_active_1_o !== 24'd7) begin failed++; $display("FAIL apply_act got %0d/%0d exp 3/7", pwm_active_0_o, pwm_active_1_o); end
  endtask

  task automatic test_slew;
    cmd_valid_i = 1'b1; cmd_period_i = 24'd4; cmd_active_0_i = 24'd100; cmd_active_1_i = 24'd100;
    cyc(1);
    cmd_valid_i = 1'b0;
    tests++; if (cmd_ready_o !== 1'b0) begin failed++; $display("FAIL slew_pend_ready got %b exp 0", cmd_ready_o); end
    cyc(8);
    tests++; if (pwm_period_o !== 24'd10) begin failed++; $display("FAIL slew_early_period got %0d exp 10", pwm_period_o); end
    cyc(1); // P0
    tests++; if (pwm_period_o !== 24'd4) begin failed++; $display("FAIL slew_period got %0d exp 4", pwm_period_o); end
    cyc(4); // P4
    tests++; if (pwm_active_0_o !== 24'd100 || pwm_active_1_o !== 24'd100) begin failed++; $display("FAIL slew_start got %0d/%0d exp 100/100", pwm_active_0_o, pwm_active_1_o); end
    slew_step_i = 16'd20;
    cmd_valid_i = 1'b1; cmd_active_0_i = 24'd150; cmd_active_1_i = 24'd50;
    cyc(1); // P5 accept
    cmd_valid_i = 1'b0;
    cyc(6); // P11
    tests++; if (pwm_active_0_o !== 24'd100) begin failed++; $display("FAIL slew_hold got %0d exp 100", pwm_active_0_o); end
    cyc(1); // P12
    tests++; if (pwm_active_0_o !== 24'd120 || pwm_active_1_o !== 24'd80) begin failed++; $display("FAIL slew_1 got %0d/%0d exp 120/80", pwm_active_0_o, pwm_active_1_o); end
    cyc(4); // P16
    tests++; if (pwm_active_0_o !== 24'd140 || pwm_active_1_o !== 24'd60) begin failed++; $display("FAIL slew_2 got %0d/%0d exp 140/60", pwm_active_0_o, pwm_active_1_o); end
    cyc(4); // P20
    tests++; if (pwm_active_0_o !== 24'd150 || pwm_active_1_o !== 24'd50) begin failed++; $display("FAIL slew_3 got %0d/%0d exp 150/50", pwm_active_0_o, pwm_active_1_o); end
    cyc(4); // P24
    tests++; if (pwm_active_0_o !== 24'd150 || pwm_active_1_o !== 24'd50) begin failed++; $display("FAIL slew_stable got %0d/%0d exp 150/50", pwm_active_0_o, pwm_active_1_o); end
  endtask

  task automatic test_watchdog;
    wdog_limit_i = 8'd3; fs_active_0_i = 24'd130; fs_active_1_i = 24'd70;
    cyc(11); // P35: two boundaries counted (P28, P32)
    tests++; if (state_o !== 2'd1 || fs_event_o !== 1'b0) begin failed++; $display("FAIL wd_early got st %0d ev %b exp st 1 ev 0", state_o, fs_event_o); end
    cyc(1); // P36: third boundary
    tests++; if (state_o !== 2'd2) begin failed++; $display("FAIL wd_fs_state got %0d exp 2", state_o); end
    tests++; if (fs_event_o !== 1'b1) begin failed++; $display("FAIL wd_fs_event got %b exp 1", fs_event_o); end
    tests++; if (pwm_period_o !== 24'd4) begin failed++; $display("FAIL wd_period got %0d exp 4", pwm_period_o); end
    cyc(1); // P37
    tests++; if (fs_event_o !== 1'b0 || state_o !== 2'd2) begin failed++; $display("FAIL wd_pulse got ev %b st %0d exp ev 0 st 2", fs_event_o, state_o); end
    tests++; if (cmd_ready_o !== 1'b1) begin failed++; $display("FAIL wd_fs_ready got %b exp 1", cmd_ready_o); end
    cyc(2); // P39
    tests++; if (pwm_active_0_o !== 24'd150 || pwm_active_1_o !== 24'd50) begin failed++; $display("FAIL wd_hold got %0d/%0d exp 150/50", pwm_active_0_o, pwm_active_1_o); end
    cyc(1); // P40
    tests++; if (pwm_active_0_o !== 24'd130 || pwm_active_1_o !== 24'd70) begin failed++; $display("FAIL wd_fs_act got %0d/%0d exp 130/70", pwm_active_0_o, pwm_active_1_o); end
    slew_step_i = 16'd0;
    cmd_valid_i = 1'b1; cmd_period_i = 24'd4; cmd_active_0_i = 24'd40; cmd_active_1_i = 24'd60;
    cyc(1); // P41 accept
    cmd_valid_i = 1'b0;
    tests++; if (state_o !== 2'd2) begin failed++; $display("FAIL fs_pend_state got %0d exp 2", state_o); end
    cyc(3); // P44 apply
    tests++; if (state_o !== 2'd1 || fs_event_o !== 1'b0) begin failed++; $display("FAIL fs_exit got st %0d ev %b exp st 1 ev 0", state_o, fs_event_o); end
    cyc(4); // P48
    tests++; if (pwm_active_0_o !== 24'd40 || pwm_active_1_o !== 24'd60) begin failed++; $display("FAIL fs_exit_act got %0d/%0d exp 40/60", pwm_active_0_o, pwm_active_1_o); end
  endtask

  task automatic test_cmd_beats_watchdog;
    cyc(5); // P53
    cmd_valid_i = 1'b1; cmd_active_0_i = 24'd5; cmd_active_1_i = 24'd6;
    cyc(1); // P54 accept
    cmd_valid_i = 1'b0;
    cyc(2); // P56: watchdog would expire, command pending
    tests++; if (state_o !== 2'd1 || fs_event_o !== 1'b0) begin failed++; $display("FAIL race_p56 got st %0d ev %b exp st 1 ev 0", state_o, fs_event_o); end
    cyc(1); // P57
    tests++; if (state_o !== 2'd1 || fs_event_o !== 1'b0) begin failed++; $display("FAIL race_p57 got st %0d ev %b exp st 1 ev 0", state_o, fs_event_o); end
    cyc(3); // P60
    tests++; if (pwm_active_0_o !== 24'd5 || pwm_active_1_o !== 24'd6) begin failed++; $display("FAIL race_act got %0d/%0d exp 5/6", pwm_active_0_o, pwm_active_1_o); end
    cyc(7); // P67: watchdog restarted at P56
    tests++; if (state_o !== 2'd1) begin failed++; $display("FAIL race_wd_restart got %0d exp 1", state_o); end
    cyc(1); // P68
    tests++; if (state_o !== 2'd2 || fs_event_o !== 1'b1) begin failed++; $display("FAIL race_wd_expire got st %0d ev %b exp st 2 ev 1", state_o, fs_event_o); end
  endtask

  task automatic test_disable_pending;
    cmd_valid_i = 1'b1; cmd_active_0_i = 24'd99; cmd_active_1_i = 24'd99;
    cyc(1); // P69 accept
    cmd_valid_i = 1'b0; enable_i = 1'b0;
    tests++; if (cmd_ready_o !== 1'b0) begin failed++; $display("FAIL dis_pend_ready got %b exp 0", cmd_ready_o); end
    cyc(1); // P70
    tests++; if (state_o !== 2'd0 || pwm_enable_o !== 1'b0 || cmd_ready_o !== 1'b0) begin failed++; $display("FAIL dis_idle got st %0d en %b rdy %b exp 0/0/0", state_o, pwm_enable_o, cmd_ready_o); end
    wdog_limit_i = 8'd0;
    cyc(10); // P80
    tests++; if (pwm_period_o !== 24'd4 || pwm_active_0_o !== 24'd5 || pwm_active_1_o !== 24'd6) begin failed++; $display("FAIL dis_hold got %0d/%0d/%0d exp 4/5/6", pwm_period_o, pwm_active_0_o, pwm_active_1_o); end
    slew_step_i = 16'd20; enable_i = 1'b1;
    cyc(1); // P81
    tests++; if (state_o !== 2'd1 || cmd_ready_o !== 1'b1 || pwm_enable_o !== 1'b1) begin failed++; $display("FAIL reen got st %0d rdy %b en %b exp 1/1/1", state_o, cmd_ready_o, pwm_enable_o); end
    cyc(3); // P84: counter restarted at 0
    tests++; if (pwm_active_0_o !== 24'd5 || pwm_active_1_o !== 24'd6) begin failed++; $display("FAIL reen_hold got %0d/%0d exp 5/6", pwm_active_0_o, pwm_active_1_o); end
    cyc(1); // P85: slew toward failsafe targets 130/70, never the discarded 99
    tests++; if (pwm_active_0_o !== 24'd25 || pwm_active_1_o !== 24'd26) begin failed++; $display("FAIL reen_slew got %0d/%0d exp 25/26", pwm_active_0_o, pwm_active_1_o); end
  endtask

  task automatic test_async_reset;
    axi_rst = 1'b1;
    #2;
    tests++; if (state_o !== 2'd0 || {pwm_enable_o, cmd_ready_o, fs_event_o} !== 3'b000) begin failed++; $display("FAIL arst_ctrl got st %0d ctl %b exp 0/000", state_o, {pwm_enable_o, cmd_ready_o, fs_event_o}); end
    tests++; if ({pwm_period_o, pwm_active_0_o, pwm_active_1_o} !== 72'd0) begin failed++; $display("FAIL arst_data got %0d/%0d/%0d exp 0/0/0", pwm_period_o, pwm_active_0_o, pwm_active_1_o); end
    cyc(2);
    axi_rst = 1'b0;
    cyc(1);
    tests++; if (state_o !== 2'd1 || pwm_active_0_o !== 24'd0 || pwm_period_o !== 24'd0) begin failed++; $display("FAIL arst_restart got st %0d act %0d per %0d exp 1/0/0", state_o, pwm_active_0_o, pwm_period_o); end
  endtask

  initial begin
    axi_rst = 1'b1; enable_i = 1'b0; cmd_valid_i = 1'b0;
    cmd_period_i = 24'd0; cmd_active_0_i = 24'd0; cmd_active_1_i = 24'd0;
    slew_step_i = 16'd0; wdog_limit_i = 8'd0;
    fs_active_0_i = 24'd0; fs_active_1_i = 24'd0;
    cyc(2);
    test_reset;
    test_basic_apply;
    test_slew;
    test_watchdog;
    test_cmd_beats_watchdog;
    test_disable_pending;
    test_async_reset;
    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
